// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI responder.
// Frame layout: command, then address, then data, all MSB first.
package spi_pkg;

   localparam int CMD_W_DEF  = 8;
   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 32;
   localparam int FRAME_BITS = CMD_W_DEF + ADDR_W_DEF + DATA_W_DEF;
   localparam int CNT_W      = $clog2(FRAME_BITS);

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4,
      IGNORE = 3'd5
   } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle
// rise/fall pulses derived from the last two synchronized samples.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_sync = r_sync[STAGES-1];
   assign o_rise = r_sync[STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder decoding command/address/data frames into local
// write strobes and read requests, returning read data on MISO.
module spi_slave
   import spi_pkg::*;
#(
   parameter int CMD_W       = CMD_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCLK,
   input  logic              MOSI,
   input  logic              ss_n,
   output logic              MISO,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              frame_err
);

   localparam logic [CNT_W-1:0] LAST_CMD_BIT  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(CMD_W + ADDR_W - 1);
   localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(CMD_W + ADDR_W + DATA_W - 1);

   logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
   logic w_ss_sync, w_ss_rise, w_ss_fall;
   logic w_mosi, w_mosi_rise, w_mosi_fall;
   logic w_unused_edges;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .i_d(SCLK),
      .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
      .clk(clk), .rst(rst), .i_d(ss_n),
      .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst(rst), .i_d(MOSI),
      .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
   );

   assign w_unused_edges = ^{w_sclk_sync, w_ss_rise, w_mosi_rise, w_mosi_fall};

   state_t            r_state;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-2:0] r_rx;
   logic [DATA_W-1:0] r_tx;
   logic [ADDR_W-1:0] r_addr;
   logic              r_is_read;
   logic              r_rd_pend;
   logic              r_miso;
   logic              r_wr_valid;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_rd_req;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_frame_err;

   // Field values as they complete, including the bit arriving this cycle.
   logic [CMD_W-1:0]  w_cmd;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   assign w_cmd  = {r_rx[CMD_W-2:0], w_mosi};
   assign w_addr = {r_rx[ADDR_W-2:0], w_mosi};
   assign w_data = {r_rx, w_mosi};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_rx        <= '0;
         r_tx        <= '0;
         r_addr      <= '0;
         r_is_read   <= 1'b0;
         r_rd_pend   <= 1'b0;
         r_miso      <= 1'b0;
         r_wr_valid  <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_rd_req    <= 1'b0;
         r_rd_addr   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_valid  <= 1'b0;
         r_rd_req    <= 1'b0;
         r_frame_err <= 1'b0;
         // Read data arrives one cycle after the request has been seen.
         r_rd_pend   <= r_rd_req;
         if (r_rd_pend) r_tx <= rd_data;

         case (r_state)
            IDLE: begin
               r_bit_cnt <= '0;
               r_rx      <= '0;
               r_miso    <= 1'b0;
               r_is_read <= 1'b0;
               if (w_ss_fall) r_state <= CMD;
            end
            CMD, ADDR, DATA: begin
               if (w_ss_sync) begin
                  r_state     <= IDLE;
                  r_frame_err <= 1'b1;
                  r_miso      <= 1'b0;
               end else if (w_sclk_rise) begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  r_rx      <= {r_rx[DATA_W-3:0], w_mosi};
                  if (r_state == CMD && r_bit_cnt == LAST_CMD_BIT) begin
                     if (w_cmd == CMD_W'(CMD_WRITE) || w_cmd == CMD_W'(CMD_READ)) begin
                        r_is_read <= (w_cmd == CMD_W'(CMD_READ));
                        r_state   <= ADDR;
                     end else begin
                        r_state <= IGNORE;
                     end
                  end else if (r_state == ADDR && r_bit_cnt == LAST_ADDR_BIT) begin
                     r_addr  <= w_addr;
                     r_state <= DATA;
                     if (r_is_read) begin
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= w_addr;
                     end
                  end else if (r_state == DATA && r_bit_cnt == LAST_DATA_BIT) begin
                     r_state <= DONE;
                     r_miso  <= 1'b0;
                     if (!r_is_read) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_addr;
                        r_wr_data  <= w_data;
                     end
                  end
               end else if (w_sclk_fall && r_state == DATA && r_is_read) begin
                  r_miso <= r_tx[DATA_W-1];
                  r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
               end
            end
            DONE, IGNORE: begin
               r_miso <= 1'b0;
               if (w_ss_sync) r_state <= IDLE;
               else if (w_sclk_rise) r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign MISO      = r_miso;
   assign wr_valid  = r_wr_valid;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign rd_req    = r_rd_req;
   assign rd_addr   = r_rd_addr;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != IDLE);

endmodule
